// File: rtl/csr_dbg_master_if.sv
// csr_dbg_master_if: host command/response channels plus the Zicsr port
// toward the CSR file, bundled for the debug CSR master.
interface csr_dbg_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        core_busy;
    logic        csr_zicsr;
    logic [11:0] csr_addr;
    logic [2:0]  csr_funct3;
    logic [31:0] csr_rs1_data;
    logic [4:0]  csr_uimm;
    logic [31:0] csr_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        input  core_busy, csr_rdata,
        output csr_zicsr, csr_addr, csr_funct3, csr_rs1_data, csr_uimm
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        output core_busy, csr_rdata,
        input  csr_zicsr, csr_addr, csr_funct3, csr_rs1_data, csr_uimm
    );
endinterface

// File: rtl/csr_dbg_master.sv
// csr_dbg_master: turns host debug commands into single Zicsr accesses.
// Define CSR_DBG_TIMEOUT_EN to abort an ISSUE stalled TIMEOUT_CYCLES cycles.
module csr_dbg_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    csr_dbg_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    state_t      state_q, state_d;
    cmd_t        cmd_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept, reject, abort;

    logic        cmd_ready, resp_valid, zicsr;
    logic [11:0] c_addr;
    logic [2:0]  c_funct3;
    logic [31:0] c_rs1;

    assign accept = bus.cmd_valid && (state_q == IDLE);

    // zero-mask set/clear never modifies a CSR, so read-only space is fine
    assign reject = (bus.cmd_op != OP_RD)
                 && (bus.cmd_addr[11:10] == 2'b11)
                 && !(((bus.cmd_op == OP_SET) || (bus.cmd_op == OP_CLR))
                      && (bus.cmd_wdata == '0));

`ifdef CSR_DBG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q != ISSUE) begin
            cnt_q <= '0;
        end else if (bus.core_busy) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign abort = (state_q == ISSUE) && bus.core_busy && (cnt_q == TLAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        zicsr      = 1'b0;
        c_addr     = '0;
        c_funct3   = '0;
        c_rs1      = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (reject) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                c_addr = cmd_q.addr;
                unique case (1'b1)
                    (cmd_q.op == OP_WR):  c_funct3 = 3'b001;
                    (cmd_q.op == OP_CLR): c_funct3 = 3'b011;
                    default:              c_funct3 = 3'b010;
                endcase
                c_rs1 = (cmd_q.op == OP_RD) ? '0 : cmd_q.wdata;
                if (!bus.core_busy) begin
                    zicsr   = 1'b1;
                    rdata_d = bus.csr_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (abort) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                cmd_q.op    <= bus.cmd_op;
                cmd_q.addr  <= bus.cmd_addr;
                cmd_q.wdata <= bus.cmd_wdata;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_err     = err_q;
    assign bus.csr_zicsr    = zicsr;
    assign bus.csr_addr     = c_addr;
    assign bus.csr_funct3   = c_funct3;
    assign bus.csr_rs1_data = c_rs1;
    assign bus.csr_uimm     = 5'd0;
endmodule

// File: tb/tb_csr_dbg_master.sv
// tb_csr_dbg_master: directed commands against a transaction-level model
// of the debug CSR master, with a small CSR file behind the Zicsr port.
`timescale 1ns/1ps
module tb_csr_dbg_master;
    localparam int TMO = 8;
`ifdef CSR_DBG_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    csr_dbg_master_if bus();

    csr_dbg_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // CSR file behind the port: combinational read, Zicsr-style update
    logic [31:0] csr_mem [0:4095];
    bit          loaded = 1'b0;
    assign bus.csr_rdata = csr_mem[bus.csr_addr];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
            csr_mem[12'h340] <= 32'hDEAD_BEEF;
            csr_mem[12'h305] <= 32'h0000_0004;
            csr_mem[12'h300] <= 32'h0000_0003;
            loaded <= 1'b1;
        end else if (bus.csr_zicsr) begin
            case (bus.csr_funct3)
                3'b001: csr_mem[bus.csr_addr] <= bus.csr_rs1_data;
                3'b010: csr_mem[bus.csr_addr] <=
                        csr_mem[bus.csr_addr] | bus.csr_rs1_data;
                3'b011: csr_mem[bus.csr_addr] <=
                        csr_mem[bus.csr_addr] & ~bus.csr_rs1_data;
                default: ;
            endcase
        end
    end

    // transaction model: what the one outstanding command must do
    function automatic bit rejects(logic [1:0] op, logic [11:0] a,
                                   logic [31:0] w);
        return (op != 2'b00) && (a[11:10] == 2'b11) && !(op[1] && w == 0);
    endfunction

    function automatic logic [2:0] f3_of(logic [1:0] op);
        case (op)
            2'b01:   return 3'b001;
            2'b11:   return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    bit          pend, acc_exp, acc_done;
    int          stalls;
    logic [11:0] e_addr;
    logic [2:0]  e_f3;
    logic [31:0] e_rs1, e_old;
    wire         tmo = TMO_EN && (stalls >= TMO);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= 1'b0;
            acc_exp  <= 1'b0;
            acc_done <= 1'b0;
            stalls   <= 0;
        end else if (!pend) begin
            if (bus.cmd_valid) begin
                pend     <= 1'b1;
                acc_done <= 1'b0;
                stalls   <= 0;
                acc_exp  <= !rejects(bus.cmd_op, bus.cmd_addr, bus.cmd_wdata);
                e_addr   <= bus.cmd_addr;
                e_f3     <= f3_of(bus.cmd_op);
                e_rs1    <= (bus.cmd_op == 2'b00) ? 32'h0 : bus.cmd_wdata;
                e_old    <= csr_mem[bus.cmd_addr];
            end
        end else begin
            if (acc_exp && !acc_done && !tmo && bus.core_busy)
                stalls <= stalls + 1;
            if (bus.csr_zicsr) acc_done <= 1'b1;
            if (bus.resp_valid && bus.resp_ready) pend <= 1'b0;
        end
    end

    // per-cycle compare of every DUT output against the model
    always @(negedge clk) begin
        if (rst && loaded) begin
            automatic bit issuing = pend && acc_exp && !acc_done && !tmo;
            automatic bit rsp = pend && (acc_done || !acc_exp || tmo);
            chk("cmd_ready", bus.cmd_ready, !pend);
            chk("csr_zicsr", bus.csr_zicsr, issuing && !bus.core_busy);
            chk("csr_addr", bus.csr_addr, issuing ? e_addr : 12'h0);
            chk("csr_funct3", bus.csr_funct3, issuing ? e_f3 : 3'h0);
            chk("csr_rs1", bus.csr_rs1_data, issuing ? e_rs1 : 32'h0);
            chk("csr_uimm", bus.csr_uimm, 5'h0);
            chk("resp_valid", bus.resp_valid, rsp);
            if (rsp) begin
                chk("resp_rdata", bus.resp_rdata, acc_done ? e_old : 32'h0);
                chk("resp_err", bus.resp_err, !acc_done);
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input int busy,
                          input int hold, output logic [31:0] rd,
                          output logic er, output int p_lat,
                          output int r_lat, output int pulses,
                          output logic [2:0] pf3, output logic [31:0] prs1);
        int  seen;
        bit  done;
        p_lat = -1; r_lat = -1; pulses = 0; seen = 0;
        rd = '0; er = 1'bx; pf3 = 'x; prs1 = 'x;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_addr   = addr;
        bus.cmd_wdata  = wd;
        bus.core_busy  = (busy > 0);
        bus.resp_ready = (hold == 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.csr_zicsr) begin
                pulses++;
                if (p_lat < 0) begin
                    p_lat = k;
                    pf3   = bus.csr_funct3;
                    prs1  = bus.csr_rs1_data;
                end
            end
            if (bus.resp_valid) begin
                if (r_lat < 0) begin
                    r_lat = k;
                    rd    = bus.resp_rdata;
                    er    = bus.resp_err;
                end
                seen++;
                if (seen > hold) bus.resp_ready = 1'b1;
            end
            done = bus.resp_valid && bus.resp_ready;
            @(posedge clk); #1;
            bus.core_busy = (k + 1 <= busy);
            if (done) break;
        end
        if (r_lat < 0) chk("resp_timeout", 32'(r_lat), 32'd0);
        bus.core_busy  = 1'b0;
        bus.resp_ready = 1'b1;
    endtask

    logic [31:0] rd, prs1;
    logic        er;
    logic [2:0]  pf3;
    int          pl, rl, np;

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_addr   = 12'h0;
        bus.cmd_wdata  = 32'h0;
        bus.resp_ready = 1'b1;
        bus.core_busy  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_zicsr", bus.csr_zicsr, 0);
        chk("rst_csr_addr", bus.csr_addr, 0);
        chk("rst_funct3", bus.csr_funct3, 0);
        chk("rst_rs1", bus.csr_rs1_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        do_cmd(2'b00, 12'h340, 32'h0, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("rd_mscratch_data", rd, 32'hDEAD_BEEF);
        chk("rd_mscratch_err", er, 0);
        chk("rd_pulse_lat", pl, 1);
        chk("rd_resp_lat", rl, 2);
        chk("rd_pulses", np, 1);
        chk("rd_f3", pf3, 3'b010);
        chk("rd_rs1", prs1, 0);

        do_cmd(2'b01, 12'h305, 32'h100, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("wr_mtvec_old", rd, 32'h4);
        chk("wr_mtvec_f3", pf3, 3'b001);
        chk("wr_mtvec_rs1", prs1, 32'h100);
        do_cmd(2'b00, 12'h305, 32'h0, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("rd_mtvec_new", rd, 32'h100);

        do_cmd(2'b01, 12'hF14, 32'h1, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("wr_ro_err", er, 1);
        chk("wr_ro_rdata", rd, 0);
        chk("wr_ro_pulses", np, 0);
        chk("wr_ro_lat", rl, 1);
        do_cmd(2'b10, 12'hF14, 32'h0, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("set0_ro_err", er, 0);
        chk("set0_ro_pulses", np, 1);
        chk("set0_ro_f3", pf3, 3'b010);

        do_cmd(2'b10, 12'h300, 32'h8, 5, 3, rd, er, pl, rl, np, pf3, prs1);
        chk("busy_pulse_lat", pl, 6);
        chk("busy_resp_lat", rl, 7);
        chk("busy_pulses", np, 1);
        chk("set_old", rd, 32'h3);
        do_cmd(2'b11, 12'h300, 32'h1, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("clr_f3", pf3, 3'b011);
        chk("clr_old", rd, 32'hB);
        do_cmd(2'b00, 12'h300, 32'h0, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("clr_result", rd, 32'hA);
        do_cmd(2'b11, 12'hC00, 32'h4, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("clr_ro_err", er, 1);
        chk("clr_ro_pulses", np, 0);

        if (TMO_EN) begin
            do_cmd(2'b00, 12'h340, 32'h0, 1000, 0,
                   rd, er, pl, rl, np, pf3, prs1);
            chk("tmo_err", er, 1);
            chk("tmo_rdata", rd, 0);
            chk("tmo_pulses", np, 0);
            chk("tmo_lat", rl, TMO + 1);
        end else begin
            do_cmd(2'b00, 12'h340, 32'h0, 20, 0,
                   rd, er, pl, rl, np, pf3, prs1);
            chk("stall_pulse_lat", pl, 21);
            chk("stall_data", rd, 32'hDEAD_BEEF);
        end

        // reset in the middle of a stalled ISSUE
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_addr  = 12'h305;
        bus.cmd_wdata = 32'h55;
        bus.core_busy = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("mid_rst_ready", bus.cmd_ready, 1);
        chk("mid_rst_zicsr", bus.csr_zicsr, 0);
        chk("mid_rst_valid", bus.resp_valid, 0);
        chk("mid_rst_addr", bus.csr_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.core_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_valid", bus.resp_valid, 0);
            chk("post_rst_zicsr", bus.csr_zicsr, 0);
        end
        do_cmd(2'b00, 12'h305, 32'h0, 0, 0, rd, er, pl, rl, np, pf3, prs1);
        chk("post_rst_mtvec", rd, 32'h100);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
